// File: rtl/fp32_accumulate.sv
// fp32_accumulate: streaming binary32 accumulator for the neuron datapath.
// It takes one product per 4 cycles, keeps a running sum, and presents the
// finished dot product when a term marked 'last' has been folded in.
// Only normal numbers are handled. Results are truncated, and NaN gets no
// special treatment.
// Optional build macro: FP32_ACC_RELU_EN. When defined, a negative final sum
// is clamped to +0 before it is presented.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | ready for a term; latch operand and last flag on valid
// ALIGN  | order acc/b by magnitude, right-shift the smaller mantissa
// ADD    | add or subtract the aligned mantissas
// NORM   | normalise, detect overflow/underflow, write acc
// DONE   | present the finished sum until the consumer takes it
module fp32_accumulate #(
  parameter int TERM_CNT_W = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  in_valid_i,
  input  logic [31:0]           in_data_i,
  input  logic                  in_last_i,
  output logic                  in_ready_o,
  output logic                  out_valid_o,
  output logic [31:0]           out_data_o,
  output logic                  out_ovf_o,
  output logic [TERM_CNT_W-1:0] out_terms_o,
  input  logic                  out_ready_i
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ALIGN = 3'd1,
    S_ADD   = 3'd2,
    S_NORM  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state, state_n;

  logic [31:0]           acc;
  logic [31:0]           b;
  logic                  last_r;
  logic                  ovf_r;
  logic [TERM_CNT_W-1:0] term_cnt;

  logic        w_sign;
  logic        w_sub;
  logic [7:0]  w_exp;
  logic [26:0] w_mb;
  logic [26:0] w_ms;
  logic [27:0] w_sum;

  // alignment signals
  logic        a_zero, b_zero, a_big;
  logic [30:0] a_mag, b_mag;
  logic [31:0] big_word, small_word;
  logic        big_zero, small_zero;
  logic [26:0] big_mant, small_raw, small_mant;
  logic [7:0]  shamt;

  // normalisation signals
  logic [4:0]         lz;
  logic [26:0]        norm_mant;
  logic signed [9:0]  norm_exp;
  logic [31:0]        acc_n;
  logic               ovf_n;
  logic               acc_inf;
  logic               unused_bits;

  // state register
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state <= S_IDLE;
    else           state <= state_n;
  end

  // next-state and handshake outputs; outputs are zero outside DONE
  always_comb begin
    state_n     = state;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    out_data_o  = '0;
    out_ovf_o   = 1'b0;
    out_terms_o = '0;
    case (state)
      S_IDLE: begin
        in_ready_o = reset_ni;
        if (in_valid_i) state_n = S_ALIGN;
      end
      S_ALIGN: state_n = S_ADD;
      S_ADD:   state_n = S_NORM;
      S_NORM:  state_n = last_r ? S_DONE : S_IDLE;
      S_DONE: begin
        out_valid_o = 1'b1;
        out_data_o  = acc;
        out_ovf_o   = ovf_r;
        out_terms_o = term_cnt - TERM_CNT_W'(1);
        if (out_ready_i) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // order operands by magnitude and align the smaller one
  always_comb begin
    a_zero     = (acc[30:23] == 8'd0);
    b_zero     = (b[30:23] == 8'd0);
    a_mag      = a_zero ? 31'd0 : acc[30:0];
    b_mag      = b_zero ? 31'd0 : b[30:0];
    a_big      = (a_mag >= b_mag);
    big_word   = a_big ? acc : b;
    small_word = a_big ? b : acc;
    big_zero   = a_big ? a_zero : b_zero;
    small_zero = a_big ? b_zero : a_zero;
    big_mant   = big_zero ? 27'd0 : {1'b1, big_word[22:0], 3'b000};
    small_raw  = small_zero ? 27'd0 : {1'b1, small_word[22:0], 3'b000};
    shamt      = big_word[30:23] - small_word[30:23];
    small_mant = (shamt >= 8'd27) ? 27'd0 : (small_raw >> shamt);
  end

  // leading-zero count of the uncarried sum; the highest set bit wins
  always_comb begin
    lz = 5'd0;
    for (int i = 0; i < 27; i++) begin
      if (w_sum[i]) lz = 5'(26 - i);
    end
  end

  // normalise and classify the result; an infinite acc absorbs later terms
  always_comb begin
    acc_inf = (acc[30:23] == 8'hFF);
    if (w_sum[27]) begin
      norm_mant = w_sum[27:1];
      norm_exp  = $signed({2'b00, w_exp}) + 10'sd1;
    end else begin
      norm_mant = w_sum[26:0] << lz;
      norm_exp  = $signed({2'b00, w_exp}) - $signed({5'b00000, lz});
    end
    acc_n = {w_sign, norm_exp[7:0], norm_mant[25:3]};
    ovf_n = ovf_r;
    if (acc_inf) begin
      acc_n = acc;
    end else if (w_sum == 28'd0) begin
      acc_n = 32'd0;
    end else if (norm_exp >= 10'sd255) begin
      acc_n = {w_sign, 8'hFF, 23'd0};
      ovf_n = 1'b1;
    end else if (norm_exp <= 10'sd0) begin
      acc_n = 32'd0;
    end
`ifdef FP32_ACC_RELU_EN
    if (last_r && acc_n[31]) begin
      acc_n = 32'd0;
      ovf_n = 1'b0;
    end
`endif
  end

  assign unused_bits = ^{norm_mant[26], norm_mant[2:0]};

  // datapath registers, advanced one pipeline step per state
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      acc      <= '0;
      b        <= '0;
      last_r   <= 1'b0;
      ovf_r    <= 1'b0;
      term_cnt <= '0;
      w_sign   <= 1'b0;
      w_sub    <= 1'b0;
      w_exp    <= '0;
      w_mb     <= '0;
      w_ms     <= '0;
      w_sum    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid_i) begin
            b      <= in_data_i;
            last_r <= in_last_i;
          end
        end
        S_ALIGN: begin
          w_sign <= big_word[31];
          w_sub  <= acc[31] ^ b[31];
          w_exp  <= big_word[30:23];
          w_mb   <= big_mant;
          w_ms   <= small_mant;
        end
        S_ADD: begin
          w_sum <= w_sub ? ({1'b0, w_mb} - {1'b0, w_ms})
                         : ({1'b0, w_mb} + {1'b0, w_ms});
        end
        S_NORM: begin
          acc      <= acc_n;
          ovf_r    <= ovf_n;
          term_cnt <= term_cnt + TERM_CNT_W'(1);
        end
        S_DONE: begin
          if (out_ready_i) begin
            acc      <= '0;
            ovf_r    <= 1'b0;
            term_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_accumulate.sv
// Directed bench for fp32_accumulate: a table of sums plus hand-written
// backpressure and mid-operation reset sequences.
module tb_fp32_accumulate;

  logic        clk_i = 1'b0;
  logic        reset_ni = 1'b0;
  logic        in_valid_i = 1'b0;
  logic [31:0] in_data_i = 32'd0;
  logic        in_last_i = 1'b0;
  logic        in_ready_o;
  logic        out_valid_o;
  logic [31:0] out_data_o;
  logic        out_ovf_o;
  logic [7:0]  out_terms_o;
  logic        out_ready_i = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  fp32_accumulate #(.TERM_CNT_W(8)) dut (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .in_valid_i (in_valid_i),
    .in_data_i  (in_data_i),
    .in_last_i  (in_last_i),
    .in_ready_o (in_ready_o),
    .out_valid_o(out_valid_o),
    .out_data_o (out_data_o),
    .out_ovf_o  (out_ovf_o),
    .out_terms_o(out_terms_o),
    .out_ready_i(out_ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [7:0]       n;
    logic [2:0][31:0] t;
    logic [31:0]      d;
    logic             ovf;
  } vec_t;

  function automatic vec_t mk(input int n, input logic [31:0] t0, input logic [31:0] t1,
                              input logic [31:0] t2, input logic [31:0] d, input logic ovf);
    vec_t v;
    v.n   = 8'(n);
    v.t   = {t2, t1, t0};
    v.d   = d;
    v.ovf = ovf;
    return v;
  endfunction

  function automatic logic [31:0] relu_d(input logic [31:0] d);
`ifdef FP32_ACC_RELU_EN
    return d[31] ? 32'd0 : d;
`else
    return d;
`endif
  endfunction

  function automatic logic relu_o(input logic [31:0] d, input logic o);
`ifdef FP32_ACC_RELU_EN
    return d[31] ? 1'b0 : o;
`else
    return o;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // present a term from a negedge, wait (bounded) for acceptance
  task automatic send_term(input logic [31:0] d, input logic last);
    int w;
    in_valid_i = 1'b1;
    in_data_i  = d;
    in_last_i  = last;
    w = 0;
    while (!in_ready_o && w < 50) begin
      @(negedge clk_i);
      w++;
    end
    check("accept_wait", 32'(in_ready_o), 32'd1);
    @(posedge clk_i);
    @(negedge clk_i);
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
  endtask

  task automatic wait_valid(output int k);
    k = 0;
    while (!out_valid_o && k < 50) begin
      @(negedge clk_i);
      k++;
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int k;
    for (int j = 0; j < int'(v.n); j++) send_term(v.t[j], (j == int'(v.n) - 1));
    wait_valid(k);
    check($sformatf("v%0d latency", idx), 32'(k), 32'd3);
    check($sformatf("v%0d valid", idx), 32'(out_valid_o), 32'd1);
    check($sformatf("v%0d data", idx), out_data_o, relu_d(v.d));
    check($sformatf("v%0d ovf", idx), 32'(out_ovf_o), 32'(relu_o(v.d, v.ovf)));
    check($sformatf("v%0d terms", idx), 32'(out_terms_o), 32'(v.n - 8'd1));
    out_ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    out_ready_i = 1'b0;
    check($sformatf("v%0d valid_drop", idx), 32'(out_valid_o), 32'd0);
    check($sformatf("v%0d ready_back", idx), 32'(in_ready_o), 32'd1);
  endtask

  vec_t vecs[14];

  initial begin
    int k;
    vecs[0]  = mk(2, 32'h3F800000, 32'h40000000, 32'h0, 32'h40400000, 1'b0);
    vecs[1]  = mk(2, 32'h40400000, 32'hC0400000, 32'h0, 32'h00000000, 1'b0);
    vecs[2]  = mk(2, 32'h3FC00000, 32'hBF800000, 32'h0, 32'h3F000000, 1'b0);
    vecs[3]  = mk(2, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h0, 32'h7F800000, 1'b1);
    vecs[4]  = mk(1, 32'h3F800000, 32'h0, 32'h0, 32'h3F800000, 1'b0);
    vecs[5]  = mk(1, 32'hC0000000, 32'h0, 32'h0, 32'hC0000000, 1'b0);
    vecs[6]  = mk(3, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h40400000, 1'b0);
    vecs[7]  = mk(3, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'hBF800000, 32'h7F800000, 1'b1);
    vecs[8]  = mk(2, 32'h3F800000, 32'h31800000, 32'h0, 32'h3F800000, 1'b0);
    vecs[9]  = mk(2, 32'h00C00000, 32'h80800000, 32'h0, 32'h00000000, 1'b0);
    vecs[10] = mk(2, 32'hBF800000, 32'hC0000000, 32'h0, 32'hC0400000, 1'b0);
    vecs[11] = mk(2, 32'hFF7FFFFF, 32'hFF7FFFFF, 32'h0, 32'hFF800000, 1'b1);
    vecs[12] = mk(2, 32'h00000001, 32'h40000000, 32'h0, 32'h40000000, 1'b0);
    vecs[13] = mk(2, 32'h3F800000, 32'h33000000, 32'h0, 32'h3F800000, 1'b0);

    // outputs held at zero during reset
    #12;
    check("rst in_ready", 32'(in_ready_o), 32'd0);
    check("rst out_valid", 32'(out_valid_o), 32'd0);
    check("rst out_data", out_data_o, 32'd0);
    check("rst out_terms", 32'(out_terms_o), 32'd0);
    @(negedge clk_i);
    reset_ni = 1'b1;
    #1;
    check("post_rst in_ready", 32'(in_ready_o), 32'd1);
    @(negedge clk_i);

    for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

    // output backpressure: hold the result, ignore a driven input term
    send_term(32'h3FC00000, 1'b1);
    wait_valid(k);
    check("bp latency", 32'(k), 32'd3);
    in_valid_i = 1'b1;
    in_data_i  = 32'h40000000;
    in_last_i  = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      check("bp valid", 32'(out_valid_o), 32'd1);
      check("bp data", out_data_o, 32'h3FC00000);
      check("bp terms", 32'(out_terms_o), 32'd0);
      check("bp in_ready", 32'(in_ready_o), 32'd0);
    end
    in_valid_i  = 1'b0;
    in_last_i   = 1'b0;
    out_ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    out_ready_i = 1'b0;
    check("bp release valid", 32'(out_valid_o), 32'd0);
    check("bp release ready", 32'(in_ready_o), 32'd1);
    run_vec(mk(1, 32'h40000000, 32'h0, 32'h0, 32'h40000000, 1'b0), 100);

    // reset pulled while the term is in ADD
    send_term(32'h40000000, 1'b0);
    @(posedge clk_i);
    #2;
    reset_ni = 1'b0;
    #1;
    check("midrst in_ready", 32'(in_ready_o), 32'd0);
    check("midrst out_valid", 32'(out_valid_o), 32'd0);
    check("midrst out_data", out_data_o, 32'd0);
    check("midrst out_ovf", 32'(out_ovf_o), 32'd0);
    check("midrst out_terms", 32'(out_terms_o), 32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    reset_ni = 1'b1;
    #1;
    check("midrst release ready", 32'(in_ready_o), 32'd1);
    @(negedge clk_i);
    run_vec(mk(1, 32'h3F800000, 32'h0, 32'h0, 32'h3F800000, 1'b0), 101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
